rs232_rx_endpoint: RTL and testbench
====================================

// Module: rs232_rx_endpoint
// PURPOSE
//  Far-end receiver for the computer's RS-232 UART output (8N1, 16x oversampled).
//  Deserialises the serial line into bytes and buffers them in a FIFO.
//  Presents the bytes on a valid/ready stream.
//  Drives CTS back to the UART so the sender pauses before the FIFO overflows.
// PARAMETERS
//  CLK_HZ      50_000_000  input clock frequency
//  BAUD        115200      line rate; DIV = round(CLK_HZ/(BAUD*16)) = 27 at defaults
//  FIFO_DEPTH  16          receive FIFO entries, power of two, >= 4
//  CTS_THRESH  12          fifo_level at which CTS is withdrawn, < FIFO_DEPTH
// PORTS
//  clk_clk            in   1   single system clock
//  reset_reset_n      in   1   asynchronous, active-low reset
//  serial_in          in   1   line from UART sout, idle high, asynchronous to clk
//  serial_in_oe       in   1   sender output enable; when 0 the line is treated as idle (1)
//  cts_n              out  1   to UART modem cts_n; 0 = clear to send
//  rx_data            out  8   head-of-FIFO byte
//  rx_valid           out  1   rx_data holds a valid byte
//  rx_ready           in   1   consumer accepts; a pop occurs when rx_valid & rx_ready
//  fifo_level         out  $clog2(FIFO_DEPTH)+1   bytes currently held
//  framing_err        out  1   one-cycle pulse when a stop bit samples 0
//  overrun_err        out  1   sticky; set when a byte is dropped because the FIFO is full
//  err_clr            in   1   synchronous clear of overrun_err
// BEHAVIOUR
//  Reset values: cts_n=1, rx_data=0, rx_valid=0, fifo_level=0, framing_err=0, overrun_err=0.
//  Input path:
//   - Line = serial_in_oe ? serial_in : 1.
//   - The line passes through a 2-flop synchroniser (reset value 1) before any use.
//  Tick counter:
//   - Counts 0..DIV-1 and emits tick at DIV-1.
//   - Reloads to 0 on start-edge detection so sampling phase aligns with the bit.
//  FSM (state advances only on ticks, except the IDLE edge):
//   - IDLE: a 1->0 edge on the synced line goes to START with sample count = 0.
//   - START: at the 8th tick, line=0 goes to DATA (bit index 0). Line=1 is a glitch:
//     return to IDLE with no error.
//   - DATA: sample every 16 ticks at mid-bit, shift LSB first. After bit 7, go to STOP.
//   - STOP: at mid-bit, line=1 pushes the byte and goes to IDLE.
//     Line=0 pulses framing_err, discards the byte and goes to BREAK.
//   - BREAK: wait for the synced line = 1, then go to IDLE (no re-trigger during a break).
//  FIFO:
//   - The push occurs in the cycle after the stop sample.
//   - rx_valid rises the cycle after the push when the FIFO was empty (first-word-fall-through).
//   - Push when full with no pop: byte dropped, overrun_err set, contents unchanged.
//   - Push and pop in the same cycle while full: both accepted, no overrun, level unchanged.
//   - Push and pop in the same cycle while empty: the pop is impossible (rx_valid=0), so only the push happens.
//   - Pointers wrap modulo FIFO_DEPTH. The full/empty distinction comes from the extra level bit.
//  Flow control:
//   - cts_n is registered: cts_n <= (fifo_level >= CTS_THRESH).
//   - Because the sender may finish an in-flight byte, the headroom FIFO_DEPTH-CTS_THRESH must be >= 2.
//  Errors:
//   - err_clr clears overrun_err.
//   - If err_clr and a new overrun occur in the same cycle, the set wins.
//  Reset mid-frame: everything returns to reset values, the FSM goes to IDLE and the FIFO empties.
//  A frame already in progress when reset is released is ignored until the line is idle-high
//  and a fresh edge arrives.
// STRUCTURE
//  Package rs232_rx_pkg holds:
//   - state enum {IDLE, START, DATA, STOP, BREAK};
//   - OVERSAMPLE=16 and MID_SAMPLE=8;
//   - function calc_div(CLK_HZ, BAUD).
//  Sub-module rs232_rx_fifo: synchronous FWFT FIFO (push, pop, full, empty, level).
//  The top level holds the synchroniser, tick counter, FSM, shift register, CTS and error logic.
// TESTING
//  1. Send 0xA5 8N1 at BAUD. Expect rx_valid=1, rx_data=0xA5, fifo_level=1 and no errors.
//     Assert rx_ready for 1 cycle; expect rx_valid=0.
//  2. Send 12 bytes with rx_ready=0. Expect cts_n=1 one cycle after level reaches 12.
//     Pop 1 byte; expect cts_n=0 one cycle later.
//  3. Send 17 bytes with rx_ready=0 (ignore CTS). Expect 16 stored and overrun_err=1.
//     Expect rx_data order 0..15 on pop. Pulse err_clr; expect overrun_err=0.
//  4. Hold the line low for 0.3 bit then release. Expect no push and no framing_err.
//     Then send 0x3C; expect 0x3C received.
//  5. Send a byte with stop bit=0, followed by a 2-frame break. Expect exactly one framing_err
//     pulse and no push. Expect no byte received until the line has returned high,
//     after which 0x55 is received correctly.
//  6. Assert reset_reset_n=0 during bit 4 of a frame. Expect all outputs at reset values
//     asynchronously. After release, expect the next full frame 0x81 to be received.

Source files
------------

// File: rtl/rs232_rx_pkg.sv
// Shared types and constants for the RS-232 receive endpoint.
// Oversampling ratio, mid-bit sample point and baud divider helper.
package rs232_rx_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} rx_state_e;

  localparam int OVERSAMPLE = 16;
  localparam int MID_SAMPLE = 8;

  function automatic int calc_div(input int clk_hz, input int baud);
    return (clk_hz + (baud * OVERSAMPLE) / 2) / (baud * OVERSAMPLE);
  endfunction

endpackage

// File: rtl/rs232_rx_fifo.sv
// First-word-fall-through byte FIFO; head is visible the cycle after a push into an empty FIFO.
// A push while full is accepted only if a pop happens in the same cycle, otherwise it is dropped.
module rs232_rx_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       push_dat_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       head_dat_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] level_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      level_q;
  logic             push_ok, pop_ok;

  assign empty_o = (level_q == '0);
  assign full_o  = (level_q == (AW+1)'(DEPTH));
  assign pop_ok  = pop_i & ~empty_o;
  assign push_ok = push_i & (~full_o | pop_ok);

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_dat_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push_ok && !pop_ok)      level_q <= level_q + 1'b1;
      else if (pop_ok && !push_ok) level_q <= level_q - 1'b1;
    end
  end

  // Memory is not reset, so an empty FIFO presents zero rather than stale data.
  assign head_dat_o = empty_o ? '0 : mem_q[rd_ptr_q];
  assign level_o    = level_q;

endmodule

// File: rtl/rs232_rx_endpoint.sv
// Deserialises 8N1 frames from a 16x-oversampled line into a FWFT FIFO with registered CTS.
// Byte is pushed one cycle after its stop sample; a full FIFO drops it and sets sticky overrun.
module rs232_rx_endpoint
  import rs232_rx_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16,
  parameter int CTS_THRESH = 12
) (
  input  logic                          clk_clk,
  input  logic                          reset_reset_n,
  input  logic                          serial_in,
  input  logic                          serial_in_oe,
  output logic                          cts_n,
  output logic [7:0]                    rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          framing_err,
  output logic                          overrun_err,
  input  logic                          err_clr
);
  localparam int DIV = calc_div(CLK_HZ, BAUD);
  localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int LW  = $clog2(FIFO_DEPTH) + 1;
  localparam int SW  = $clog2(OVERSAMPLE);

  logic          line, sync1_q, sync2_q, prev_q, armed_q;
  logic [1:0]    flush_q;
  logic [TW-1:0] tick_cnt_q;
  logic          tick, fall, start_mid, bit_mid;
  rx_state_e     state_q, state_d;
  logic [SW-1:0] samp_cnt_q;
  logic [2:0]    bit_idx_q;
  logic [7:0]    shift_q;
  logic          start_edge, cnt_clr, data_smp, stop_good, stop_bad;
  logic          push_q, framing_q, overrun_q, overrun_d, cts_n_q;
  logic          fifo_full, fifo_empty, pop_ok;

  assign line = serial_in_oe ? serial_in : 1'b1;

  // Edges are trusted only after the reset value has flushed out of the synchroniser
  // and a real idle-high has been seen, so a frame cut by reset cannot restart reception.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      flush_q <= '0;
      armed_q <= 1'b0;
    end else begin
      sync1_q <= line;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      flush_q <= {flush_q[0], 1'b1};
      armed_q <= armed_q | (flush_q[1] & sync2_q);
    end
  end

  assign fall      = armed_q & prev_q & ~sync2_q;
  assign tick      = (tick_cnt_q == TW'(DIV - 1));
  assign start_mid = tick & (samp_cnt_q == SW'(MID_SAMPLE - 1));
  assign bit_mid   = tick & (samp_cnt_q == SW'(OVERSAMPLE - 1));

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n)         tick_cnt_q <= '0;
    else if (start_edge || tick) tick_cnt_q <= '0;
    else                         tick_cnt_q <= tick_cnt_q + 1'b1;
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) state_q <= IDLE;
    else                state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (fall)      state_d = START;
      START:   if (start_mid) state_d = sync2_q ? IDLE : DATA;
      DATA:    if (bit_mid && bit_idx_q == 3'd7) state_d = STOP;
      STOP:    if (bit_mid)   state_d = sync2_q ? IDLE : BREAK;
      BREAK:   if (sync2_q)   state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  always_comb begin
    start_edge = 1'b0;
    cnt_clr    = 1'b0;
    data_smp   = 1'b0;
    stop_good  = 1'b0;
    stop_bad   = 1'b0;
    unique case (state_q)
      IDLE:    start_edge = fall;
      START:   cnt_clr    = start_mid & ~sync2_q;
      DATA:    data_smp   = bit_mid;
      STOP: begin
        stop_good = bit_mid & sync2_q;
        stop_bad  = bit_mid & ~sync2_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      samp_cnt_q <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      push_q     <= 1'b0;
      framing_q  <= 1'b0;
    end else begin
      if (start_edge || cnt_clr) samp_cnt_q <= '0;
      else if (tick)             samp_cnt_q <= samp_cnt_q + 1'b1;
      if (start_edge)    bit_idx_q <= '0;
      else if (data_smp) bit_idx_q <= bit_idx_q + 1'b1;
      if (data_smp) shift_q <= {sync2_q, shift_q[7:1]};
      push_q    <= stop_good;
      framing_q <= stop_bad;
    end
  end

  rs232_rx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
    .clk_i      (clk_clk),
    .rst_ni     (reset_reset_n),
    .push_i     (push_q),
    .push_dat_i (shift_q),
    .pop_i      (rx_ready),
    .head_dat_o (rx_data),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .level_o    (fifo_level)
  );

  assign pop_ok    = rx_ready & ~fifo_empty;
  assign overrun_d = (push_q & fifo_full & ~pop_ok) | (overrun_q & ~err_clr);

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      overrun_q <= 1'b0;
      cts_n_q   <= 1'b1;
    end else begin
      overrun_q <= overrun_d;
      cts_n_q   <= (fifo_level >= LW'(CTS_THRESH));
    end
  end

  assign rx_valid    = ~fifo_empty;
  assign framing_err = framing_q;
  assign overrun_err = overrun_q;
  assign cts_n       = cts_n_q;

endmodule

// File: tb/tb_rs232_rx_endpoint.sv
// Bench for rs232_rx_endpoint: vector table, directed corner sequences and a random queue-model run.
module tb_rs232_rx_endpoint;
  localparam int CLK_HZ = 7_372_800;
  localparam int BAUD   = 115200;
  localparam int BIT    = CLK_HZ / BAUD;   // clock cycles per serial bit

  logic       clk = 1'b0, rst_n = 1'b1, ser = 1'b1, oe = 1'b1, rx_ready = 1'b0, err_clr = 1'b0;
  logic       cts_n, rx_valid, framing_err, overrun_err;
  logic [7:0] rx_data;
  logic [4:0] fifo_level;

  int checks = 0, errors = 0, ferr_cnt = 0;

  rs232_rx_endpoint #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .FIFO_DEPTH(16), .CTS_THRESH(12)) dut (
    .clk_clk(clk), .reset_reset_n(rst_n), .serial_in(ser), .serial_in_oe(oe),
    .cts_n(cts_n), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .fifo_level(fifo_level), .framing_err(framing_err), .overrun_err(overrun_err),
    .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (framing_err) ferr_cnt++;

  initial begin
    repeat (95000) @(posedge clk);
    $display("FAIL watchdog: simulation did not complete within cycle budget");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input int cycles);
    ser = v;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int idle_bits);
    @(negedge clk);
    drive(1'b0, BIT);
    for (int i = 0; i < 8; i++) drive(b[i], BIT);
    drive(stop_bit, BIT);
    drive(1'b1, idle_bits * BIT);
  endtask

  task automatic pop_expect(input logic [7:0] exp, input string name);
    @(negedge clk);
    check({name, " valid"}, 32'(rx_valid), 32'd1);
    check({name, " data"}, 32'(rx_data), 32'(exp));
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  typedef struct {
    logic [7:0] dat;
    logic       stop_ok;
    logic       exp_valid;
    logic [7:0] exp_dat;
    int         exp_ferr;
  } vec_t;

  vec_t       tbl[6];
  logic [7:0] exp_q[$];
  logic [7:0] b;
  logic       r, bad, send_done;
  int         f0, exp_ferr, guard, k;

  initial begin
    tbl[0] = '{8'hA5, 1'b1, 1'b1, 8'hA5, 0};
    tbl[1] = '{8'h00, 1'b1, 1'b1, 8'h00, 0};
    tbl[2] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 0};
    tbl[3] = '{8'h01, 1'b1, 1'b1, 8'h01, 0};
    tbl[4] = '{8'h80, 1'b1, 1'b1, 8'h80, 0};
    tbl[5] = '{8'h5A, 1'b0, 1'b0, 8'h00, 1};

    #1 rst_n = 1'b0;
    #1;
    check("rst cts_n", 32'(cts_n), 32'd1);
    check("rst rx_valid", 32'(rx_valid), 32'd0);
    check("rst rx_data", 32'(rx_data), 32'd0);
    check("rst level", 32'(fifo_level), 32'd0);
    check("rst framing", 32'(framing_err), 32'd0);
    check("rst overrun", 32'(overrun_err), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check("idle cts_n", 32'(cts_n), 32'd0);

    // Vector table: good frames, then a stop-bit error followed by a short break.
    for (int i = 0; i < 6; i++) begin
      f0 = ferr_cnt;
      send_frame(tbl[i].dat, tbl[i].stop_ok, tbl[i].stop_ok ? 2 : 0);
      if (!tbl[i].stop_ok) begin
        drive(1'b0, 2 * BIT);
        drive(1'b1, 2 * BIT);
      end
      @(negedge clk);
      check($sformatf("tbl%0d valid", i), 32'(rx_valid), 32'(tbl[i].exp_valid));
      if (tbl[i].exp_valid) check($sformatf("tbl%0d data", i), 32'(rx_data), 32'(tbl[i].exp_dat));
      check($sformatf("tbl%0d level", i), 32'(fifo_level), 32'(tbl[i].exp_valid));
      check($sformatf("tbl%0d framing", i), 32'(ferr_cnt - f0), 32'(tbl[i].exp_ferr));
      check($sformatf("tbl%0d overrun", i), 32'(overrun_err), 32'd0);
      if (rx_valid) begin
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
      end
      check($sformatf("tbl%0d after pop", i), 32'(rx_valid), 32'd0);
    end

    // CTS threshold.
    for (int i = 0; i < 11; i++) send_frame(8'(8'h10 + i), 1'b1, 1);
    check("cts lvl11", 32'(fifo_level), 32'd11);
    check("cts at 11", 32'(cts_n), 32'd0);
    fork
      send_frame(8'h1B, 1'b1, 1);
      begin
        k = 0;
        while (fifo_level != 5'd12 && k < 2 * 10 * BIT) begin
          @(negedge clk);
          k++;
        end
        check("cts reach 12", 32'(fifo_level), 32'd12);
        check("cts same cycle", 32'(cts_n), 32'd0);
        @(negedge clk);
        check("cts next cycle", 32'(cts_n), 32'd1);
      end
    join
    pop_expect(8'h10, "cts pop");
    check("cts lvl after pop", 32'(fifo_level), 32'd11);
    check("cts still high", 32'(cts_n), 32'd1);
    @(negedge clk);
    check("cts released", 32'(cts_n), 32'd0);
    for (int i = 1; i < 12; i++) pop_expect(8'(8'h10 + i), $sformatf("cts drain%0d", i));
    check("cts drained", 32'(fifo_level), 32'd0);

    // Overrun: 17 bytes into 16 entries.
    for (int i = 0; i < 16; i++) send_frame(8'(i), 1'b1, 1);
    check("ovr full level", 32'(fifo_level), 32'd16);
    check("ovr not yet", 32'(overrun_err), 32'd0);
    send_frame(8'hEE, 1'b1, 1);
    check("ovr level kept", 32'(fifo_level), 32'd16);
    check("ovr set", 32'(overrun_err), 32'd1);
    for (int i = 0; i < 16; i++) pop_expect(8'(i), $sformatf("ovr pop%0d", i));
    check("ovr empty", 32'(fifo_level), 32'd0);
    check("ovr sticky", 32'(overrun_err), 32'd1);
    @(negedge clk) err_clr = 1'b1;
    @(negedge clk) err_clr = 1'b0;
    check("ovr cleared", 32'(overrun_err), 32'd0);

    // Short glitch on the line.
    f0 = ferr_cnt;
    @(negedge clk);
    drive(1'b0, (BIT * 3) / 10);
    drive(1'b1, 12 * BIT);
    check("glitch no push", 32'(fifo_level), 32'd0);
    check("glitch no ferr", 32'(ferr_cnt - f0), 32'd0);
    send_frame(8'h3C, 1'b1, 1);
    pop_expect(8'h3C, "glitch 3C");

    // Disabled driver: a low line with oe=0 is idle.
    oe = 1'b0;
    drive(1'b0, 12 * BIT);
    check("oe no push", 32'(fifo_level), 32'd0);
    check("oe no ferr", 32'(ferr_cnt - f0), 32'd0);
    ser = 1'b1;
    oe  = 1'b1;
    drive(1'b1, 2 * BIT);

    // Bad stop bit followed by a two-frame break.
    f0 = ferr_cnt;
    send_frame(8'hC3, 1'b0, 0);
    drive(1'b0, 20 * BIT);
    check("brk no push", 32'(fifo_level), 32'd0);
    check("brk one ferr", 32'(ferr_cnt - f0), 32'd1);
    drive(1'b1, 2 * BIT);
    send_frame(8'h55, 1'b1, 1);
    pop_expect(8'h55, "brk 55");
    check("brk ferr total", 32'(ferr_cnt - f0), 32'd1);

    // Reset during bit 4 of a frame, with a byte left in the FIFO.
    send_frame(8'h42, 1'b1, 1);
    check("mid-rst pre valid", 32'(rx_valid), 32'd1);
    fork
      begin
        send_frame(8'h0F, 1'b1, 0);
        drive(1'b1, 3 * BIT);
      end
      begin
        repeat (5 * BIT + 20) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid-rst cts_n", 32'(cts_n), 32'd1);
        check("mid-rst valid", 32'(rx_valid), 32'd0);
        check("mid-rst data", 32'(rx_data), 32'd0);
        check("mid-rst level", 32'(fifo_level), 32'd0);
        check("mid-rst framing", 32'(framing_err), 32'd0);
        check("mid-rst overrun", 32'(overrun_err), 32'd0);
        @(negedge clk) rst_n = 1'b1;
      end
    join
    check("post-rst no push", 32'(fifo_level), 32'd0);
    send_frame(8'h81, 1'b1, 1);
    pop_expect(8'h81, "post-rst 81");

    // Random frames against a queue model, with a random-ready consumer.
    f0        = ferr_cnt;
    exp_ferr  = 0;
    send_done = 1'b0;
    guard     = 0;
    fork
      begin
        for (int i = 0; i < 14; i++) begin
          b   = 8'($urandom);
          bad = ($urandom_range(0, 5) == 0);
          if (bad) begin
            exp_ferr++;
            send_frame(b, 1'b0, 0);
            drive(1'b0, $urandom_range(1, 12) * BIT);
            drive(1'b1, 2 * BIT);
          end else begin
            exp_q.push_back(b);
            send_frame(b, 1'b1, $urandom_range(0, 3));
          end
        end
        drive(1'b1, 2 * BIT);
        send_done = 1'b1;
      end
      begin
        while (!(send_done && exp_q.size() == 0 && !rx_valid) && guard < 30000) begin
          @(negedge clk);
          guard++;
          r = 1'($urandom_range(0, 1));
          if (rx_valid && r) begin
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL rand extra: got byte 0x%0h, want none", rx_data);
            end else begin
              check("rand pop", 32'(rx_data), 32'(exp_q.pop_front()));
            end
          end
          rx_ready = r;
        end
        rx_ready = 1'b0;
      end
    join
    check("rand drained", 32'(exp_q.size()), 32'd0);
    check("rand ferr", 32'(ferr_cnt - f0), 32'(exp_ferr));
    check("rand overrun", 32'(overrun_err), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
